imm_encoder: RTL

Instruction-word encoder that packs register fields and a 32-bit immediate into a RISC-V RV32I instruction word. It is the inverse of the core's immediate extender. It also expands a load-immediate pseudo-op into a LUI/ADDI pair. It sits between the test-program generator / debug-injection path and the instruction memory write port. A valid/ready handshake is used on both sides, with a single registered output slot.

---
 rtl/imm_encoder_if.sv | 30 +++
 rtl/imm_encoder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/response bundle for the RV32I instruction encoder
interface imm_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_last;

   modport master (
      output in_valid, in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
      input  in_ready,
      input  out_valid, out_inst, out_last,
      output out_ready
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
      output in_ready,
      output out_valid, out_inst, out_last,
      input  out_ready
   );
endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - packs register fields and an immediate into an RV32I word, expands LI
module imm_encoder (
   input  logic               clk,
   input  logic               reset,
   imm_encoder_if.slave       bus,
   output logic               err,
   output logic [7:0]         err_cnt
);
   typedef enum logic [0:0] {S_IDLE, S_SECOND} state_t;

   state_t      state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic        out_last_q, out_last_d;
   logic [31:0] pend_q, pend_d;
   logic        err_q, err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic        in_ready_c, accept_c;
   logic        reject_c, pair_c;
   logic [31:0] word0_c, word1_c;
   logic [31:0] imm, li_sum;
   logic        fits11, fits12, fits20;

   assign imm = bus.in_imm;
   assign li_sum = imm + 32'h0000_0800;
   // Upper bits all copies of the sign bit -> value fits the signed field
   assign fits11 = (imm[31:11] == 21'h0) || (imm[31:11] == {21{1'b1}});
   assign fits12 = (imm[31:12] == 20'h0) || (imm[31:12] == {20{1'b1}});
   assign fits20 = (imm[31:20] == 12'h0) || (imm[31:20] == {12{1'b1}});

   always_comb begin
      reject_c = 1'b0;
      pair_c   = 1'b0;
      word0_c  = 32'h0;
      word1_c  = 32'h0;
      case (bus.in_fmt)
         3'd0, 3'd1: begin
            reject_c = (bus.in_fmt == 3'd0) ? (imm[31:12] != 20'h0) : !fits11;
            word0_c  = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
         end
         3'd2: begin
            reject_c = !fits11;
            word0_c  = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
         end
         3'd3: begin
            reject_c = imm[0] || !fits12;
            word0_c  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:1], imm[11], bus.in_opcode};
         end
         3'd4: begin
            reject_c = (imm[11:0] != 12'h0);
            word0_c  = {imm[31:12], bus.in_rd, bus.in_opcode};
         end
         3'd5: begin
            reject_c = imm[0] || !fits20;
            word0_c  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
         end
         3'd6: begin
            if (fits11) begin
               word0_c = {imm[11:0], 5'd0, 3'd0, bus.in_rd, 7'h13};
            end else begin
               // LUI rounds up so that the sign-extended ADDI offset lands on imm
               word0_c = {li_sum[31:12], bus.in_rd, 7'h37};
               word1_c = {imm[11:0], bus.in_rd, 3'd0, bus.in_rd, 7'h13};
               pair_c  = (imm[11:0] != 12'h0);
            end
         end
         default: reject_c = 1'b1;
      endcase
   end

   assign in_ready_c = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept_c   = bus.in_valid && in_ready_c;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_last_d  = out_last_q;
      pend_d      = pend_q;
      err_d       = accept_c && reject_c;
      err_cnt_d   = err_cnt_q;
      if (accept_c && reject_c && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
      case (state_q)
         S_IDLE: begin
            if (accept_c && !reject_c) begin
               out_valid_d = 1'b1;
               out_inst_d  = word0_c;
               out_last_d  = !pair_c;
               if (pair_c) begin
                  pend_d  = word1_c;
                  state_d = S_SECOND;
               end
            end else if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         S_SECOND: begin
            if (bus.out_ready) begin
               out_inst_d = pend_q;
               out_last_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         out_inst_q  <= 32'h0;
         out_last_q  <= 1'b0;
         pend_q      <= 32'h0;
         err_q       <= 1'b0;
         err_cnt_q   <= 8'h0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_last_q  <= out_last_d;
         pend_q      <= pend_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_inst  = out_inst_q;
   assign bus.out_last  = out_last_q;
   assign err           = err_q;
   assign err_cnt       = err_cnt_q;
endmodule
